// File: rtl/uex_irq_pkg.sv
// Shared types and limits for the interrupt dispatch controller.
package uex_irq_pkg;

    localparam int unsigned UEX_IRQ_MAX_N = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } uex_irq_state_e;

endpackage

// File: rtl/uex_irq_arb.sv
// Interrupt arbiter: picks one eligible channel, fixed-priority or round-robin.
module uex_irq_arb
    import uex_irq_pkg::*;
#(
    parameter int unsigned  N_IRQ = 8,
    parameter bit           RR_EN = 1'b1,
    localparam int unsigned ID_W  = (N_IRQ > 2) ? $clog2(N_IRQ) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_IRQ-1:0] eligible,
    input  logic             grant,
    output logic [ID_W-1:0]  winner_id,
    output logic             any_valid
);

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    base_c;
    logic [ID_W-1:0]    offset_c;
    logic [2*N_IRQ-1:0] doubled_c;
    logic [N_IRQ-1:0]   rotated_c;
    logic [ID_W:0]      sum_c;
    logic [ID_W:0]      next_ptr_c;

    // Rotate the request vector so the search base sits at bit 0.
    assign base_c    = RR_EN ? ptr_q : '0;
    assign doubled_c = {eligible, eligible} >> base_c;
    assign rotated_c = doubled_c[N_IRQ-1:0];
    assign any_valid = |eligible;

    // Lowest set bit of the rotated vector is the distance from the base.
    always_comb begin
        offset_c = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (rotated_c[i]) begin
                offset_c = ID_W'(i);
            end
        end
    end

    // Map the distance back to an absolute channel index, modulo N_IRQ.
    always_comb begin
        sum_c = {1'b0, base_c} + {1'b0, offset_c};
        if (sum_c >= (ID_W+1)'(N_IRQ)) begin
            sum_c = sum_c - (ID_W+1)'(N_IRQ);
        end
    end

    assign winner_id = sum_c[ID_W-1:0];

    // Search base for the next round: one past the channel just granted.
    always_comb begin
        next_ptr_c = {1'b0, winner_id} + (ID_W+1)'(1);
        if (next_ptr_c >= (ID_W+1)'(N_IRQ)) begin
            next_ptr_c = '0;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (RR_EN && grant) begin
            ptr_q <= next_ptr_c[ID_W-1:0];
        end
    end

endmodule

// File: rtl/uex_irq_ctrl.sv
// Interrupt controller: latches sources, masks them and dispatches one at a time.
module uex_irq_ctrl
    import uex_irq_pkg::*;
#(
    parameter int unsigned      N_IRQ     = 8,
    parameter logic [N_IRQ-1:0] EDGE_MASK = '0,
    parameter bit               RR_EN     = 1'b1,
    localparam int unsigned     ID_W      = (N_IRQ > 2) ? $clog2(N_IRQ) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             mask_wr,
    input  logic [N_IRQ-1:0] mask_wdata,
    output logic [N_IRQ-1:0] mask_o,
    output logic [N_IRQ-1:0] pending_o,
    output logic             req_valid,
    output logic [ID_W-1:0]  req_id,
    input  logic             req_ready,
    input  logic             eoi,
    output logic             busy_o,
    output logic [31:0]      irq_count_o
);

    if (N_IRQ < 2 || N_IRQ > UEX_IRQ_MAX_N) begin : g_bad_n
        $error("uex_irq_ctrl: N_IRQ out of range");
    end

    uex_irq_state_e   state_q, state_d;
    logic [N_IRQ-1:0] prev_q, pending_q, mask_q;
    logic             req_valid_q, busy_q;
    logic [ID_W-1:0]  req_id_q;
    logic [31:0]      count_q;

    logic [N_IRQ-1:0] id_onehot_c, inservice_c, eligible_c;
    logic [N_IRQ-1:0] rise_c, edge_clr_c, pending_d;
    logic             handshake_c, grant_c;
    logic             any_valid;
    logic [ID_W-1:0]  winner_id;

    // Eligibility and pending-update terms.
    assign id_onehot_c = N_IRQ'(1) << req_id_q;
    assign handshake_c = (state_q == REQ) && req_ready;
    assign grant_c     = (state_q == IDLE) && any_valid;
    assign inservice_c = (state_q == ACTIVE) ? id_onehot_c : '0;
    assign eligible_c  = pending_q & mask_q & ~inservice_c;
    assign rise_c      = irq_i & ~prev_q;
    assign edge_clr_c  = handshake_c ? id_onehot_c : '0;
    // A rising edge wins over a same-cycle handshake clear.
    assign pending_d   = (EDGE_MASK & ((pending_q & ~edge_clr_c) | rise_c))
                       | (~EDGE_MASK & irq_i);

    uex_irq_arb #(
        .N_IRQ (N_IRQ),
        .RR_EN (RR_EN)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .eligible  (eligible_c),
        .grant     (grant_c),
        .winner_id (winner_id),
        .any_valid (any_valid)
    );

    // Dispatch FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_valid) state_d = REQ;
            REQ:     if (req_ready) state_d = ACTIVE;
            ACTIVE:  if (eoi)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Dispatch FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Source history, pending, mask, request and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q      <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_id_q    <= '0;
            count_q     <= '0;
        end else begin
            prev_q      <= irq_i;
            pending_q   <= pending_d;
            req_valid_q <= (state_d == REQ);
            busy_q      <= (state_d == ACTIVE);
            if (mask_wr) begin
                mask_q <= mask_wdata;
            end
            if (grant_c) begin
                req_id_q <= winner_id;
            end
            if (handshake_c) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign mask_o      = mask_q;
    assign pending_o   = pending_q;
    assign req_valid   = req_valid_q;
    assign req_id      = req_id_q;
    assign busy_o      = busy_q;
    assign irq_count_o = count_q;

endmodule

// File: tb/tb_uex_irq_ctrl.sv
// Bench for uex_irq_ctrl: two configurations against a cycle-level reference model.
module tb_uex_irq_ctrl;

    localparam logic [7:0] EM_A = 8'h30;
    localparam logic [7:0] EM_B = 8'h01;
    localparam bit         RR_A = 1'b1;
    localparam bit         RR_B = 1'b0;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  irq_i, mask_wdata;
    logic        mask_wr, req_ready, eoi;

    logic [7:0]  mask_a, pend_a, mask_b, pend_b;
    logic        rv_a, busy_a, rv_b, busy_b;
    logic [2:0]  rid_a, rid_b;
    logic [31:0] cnt_a, cnt_b;

    // reference model state: mode 0=waiting, 1=requesting, 2=in service
    int          m_mode [2];
    int          m_rid  [2];
    int          m_ptr  [2];
    logic [7:0]  m_pend [2];
    logic [7:0]  m_mask [2];
    logic [7:0]  m_prev [2];
    logic [31:0] m_cnt  [2];

    int hs_a[$];
    int hs_b[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    uex_irq_ctrl #(.N_IRQ(8), .EDGE_MASK(EM_A), .RR_EN(RR_A)) u_dut_a (
        .clock(clock), .reset(reset), .irq_i(irq_i), .mask_wr(mask_wr),
        .mask_wdata(mask_wdata), .mask_o(mask_a), .pending_o(pend_a),
        .req_valid(rv_a), .req_id(rid_a), .req_ready(req_ready), .eoi(eoi),
        .busy_o(busy_a), .irq_count_o(cnt_a)
    );

    uex_irq_ctrl #(.N_IRQ(8), .EDGE_MASK(EM_B), .RR_EN(RR_B)) u_dut_b (
        .clock(clock), .reset(reset), .irq_i(irq_i), .mask_wr(mask_wr),
        .mask_wdata(mask_wdata), .mask_o(mask_b), .pending_o(pend_b),
        .req_valid(rv_b), .req_id(rid_b), .req_ready(req_ready), .eoi(eoi),
        .busy_o(busy_b), .irq_count_o(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] edge_of(input int k);
        return (k == 0) ? EM_A : EM_B;
    endfunction

    function automatic bit rr_of(input int k);
        return (k == 0) ? RR_A : RR_B;
    endfunction

    function automatic void m_reset(input int k);
        m_mode[k] = 0; m_rid[k] = 0; m_ptr[k] = 0;
        m_pend[k] = '0; m_mask[k] = '0; m_prev[k] = '0; m_cnt[k] = '0;
    endfunction

    // first pending+enabled channel scanning upward from the search base
    function automatic int pick(input int k);
        int base = rr_of(k) ? m_ptr[k] : 0;
        for (int off = 0; off < 8; off++) begin
            int idx = (base + off) % 8;
            if (m_pend[k][idx] && m_mask[k][idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void model_step(input int k);
        logic [7:0] em = edge_of(k);
        logic [7:0] np;
        int         w;
        if (reset) begin
            m_reset(k);
            return;
        end
        for (int i = 0; i < 8; i++) begin
            if (em[i]) begin
                logic p = m_pend[k][i];
                if (m_mode[k] == 1 && req_ready && m_rid[k] == i) p = 1'b0;
                if (irq_i[i] && !m_prev[k][i]) p = 1'b1;
                np[i] = p;
            end else begin
                np[i] = irq_i[i];
            end
        end
        case (m_mode[k])
            0: begin
                w = pick(k);
                if (w >= 0) begin
                    m_rid[k]  = w;
                    m_mode[k] = 1;
                    if (rr_of(k)) m_ptr[k] = (w + 1) % 8;
                end
            end
            1: if (req_ready) begin
                m_mode[k] = 2;
                m_cnt[k]  = m_cnt[k] + 32'd1;
            end
            default: if (eoi) m_mode[k] = 0;
        endcase
        m_pend[k] = np;
        if (mask_wr) m_mask[k] = mask_wdata;
        m_prev[k] = irq_i;
    endfunction

    task automatic compare(input int k, input string nm, input logic [7:0] mask,
                           input logic [7:0] pend, input logic rv, input logic [2:0] rid,
                           input logic busy, input logic [31:0] cnt);
        check({nm, "_mask"},      32'(mask), 32'(m_mask[k]));
        check({nm, "_pending"},   32'(pend), 32'(m_pend[k]));
        check({nm, "_req_valid"}, 32'(rv),   32'(m_mode[k] == 1));
        check({nm, "_req_id"},    32'(rid),  32'(m_rid[k]));
        check({nm, "_busy"},      32'(busy), 32'(m_mode[k] == 2));
        check({nm, "_count"},     cnt,       m_cnt[k]);
    endtask

    task automatic tick();
        if (!reset && rv_a && req_ready) hs_a.push_back(int'(rid_a));
        if (!reset && rv_b && req_ready) hs_b.push_back(int'(rid_b));
        @(posedge clock);
        model_step(0);
        model_step(1);
        #1;
        compare(0, "a", mask_a, pend_a, rv_a, rid_a, busy_a, cnt_a);
        compare(1, "b", mask_b, pend_b, rv_b, rid_b, busy_b, cnt_b);
    endtask

    task automatic apply_reset();
        reset = 1'b1; irq_i = '0; mask_wr = 1'b0; mask_wdata = '0;
        req_ready = 1'b0; eoi = 1'b0;
        tick(); tick();
        reset = 1'b0;
        hs_a.delete(); hs_b.delete();
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_wr = 1'b1; mask_wdata = v;
        tick();
        mask_wr = 1'b0;
    endtask

    // end-of-interrupt follows the chosen instance's busy flag
    task automatic run_auto(input int n, input int which);
        for (int i = 0; i < n; i++) begin
            eoi = (which == 0) ? busy_a : busy_b;
            tick();
        end
        eoi = 1'b0;
    endtask

    initial begin
        m_reset(0); m_reset(1);
        apply_reset();

        // round-robin alternation between two held level channels
        write_mask(8'hFF);
        irq_i = 8'h81; req_ready = 1'b1;
        run_auto(24, 0);
        check("rr_dispatch_count", 32'(hs_a.size() >= 4), 32'd1);
        check("rr_id0", 32'(hs_a[0]), 32'd0);
        check("rr_id1", 32'(hs_a[1]), 32'd7);
        check("rr_id2", 32'(hs_a[2]), 32'd0);
        check("rr_id3", 32'(hs_a[3]), 32'd7);

        // fixed priority starves the higher index
        apply_reset();
        write_mask(8'hFF);
        irq_i = 8'h0C; req_ready = 1'b1;
        run_auto(24, 1);
        check("fp_dispatch_count", 32'(hs_b.size() >= 4), 32'd1);
        foreach (hs_b[i]) check("fp_id", 32'(hs_b[i]), 32'd2);

        // edge pulse while masked is dispatched once after unmask
        apply_reset();
        irq_i = 8'h01; tick();
        irq_i = 8'h00;
        for (int i = 0; i < 10; i++) tick();
        check("edge_held_pending", 32'(pend_b[0]), 32'd1);
        write_mask(8'h01);
        req_ready = 1'b1;
        run_auto(12, 1);
        check("edge_one_dispatch", 32'(hs_b.size()), 32'd1);
        check("edge_dispatch_id", 32'(hs_b[0]), 32'd0);
        check("edge_pending_clr", 32'(pend_b[0]), 32'd0);

        // stalled request stays stable through a mask clear
        apply_reset();
        write_mask(8'hFF);
        irq_i = 8'h10; req_ready = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                mask_wr = 1'b1; mask_wdata = 8'h00;
            end else begin
                mask_wr = 1'b0;
            end
            tick();
            check("stall_valid", 32'(rv_a), 32'd1);
            check("stall_id", 32'(rid_a), 32'd4);
        end
        mask_wr = 1'b0; req_ready = 1'b1;
        run_auto(8, 0);

        // re-pulse in the handshake cycle keeps pending and redispatches
        apply_reset();
        write_mask(8'h01);
        irq_i = 8'h01; tick();
        irq_i = 8'h00; tick();
        check("repulse_req", 32'(rv_b), 32'd1);
        irq_i = 8'h01; req_ready = 1'b1;
        tick();
        check("repulse_pending", 32'(pend_b[0]), 32'd1);
        check("repulse_busy", 32'(busy_b), 32'd1);
        irq_i = 8'h00;
        run_auto(10, 1);
        check("repulse_two_dispatches", 32'(hs_b.size()), 32'd2);

        // asynchronous reset while in service
        apply_reset();
        write_mask(8'hFF);
        irq_i = 8'h81; req_ready = 1'b1;
        tick(); tick(); tick();
        check("pre_reset_busy", 32'(busy_a), 32'd1);
        #2 reset = 1'b1;
        #1;
        m_reset(0); m_reset(1);
        check("async_busy", 32'(busy_a), 32'd0);
        check("async_valid", 32'(rv_a), 32'd0);
        check("async_count", cnt_a, 32'd0);
        compare(0, "a_async", mask_a, pend_a, rv_a, rid_a, busy_a, cnt_a);
        compare(1, "b_async", mask_b, pend_b, rv_b, rid_b, busy_b, cnt_b);
        reset = 1'b0;
        write_mask(8'hFF);
        run_auto(10, 0);

        // randomized traffic
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] flip = '0;
            for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 7) == 0);
            irq_i      = irq_i ^ flip;
            mask_wr    = ($urandom_range(0, 9) == 0);
            mask_wdata = 8'($urandom);
            req_ready  = ($urandom_range(0, 1) == 1);
            eoi        = ($urandom_range(0, 3) == 0);
            reset      = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
